// File: rtl/simon_keyed_core.sv
// Iterative Simon block cipher with on-chip key expansion and encrypt/decrypt mode.
// Valid/ready on both sides; the round-key file survives reset and is rewritten by key_load.
module simon_keyed_core #(
   parameter int unsigned N      = 16,
   parameter int unsigned M      = 4,
   parameter int unsigned T      = 32,
   parameter int unsigned UNROLL = 1,
   parameter logic [61:0] Z      = 62'h19C3522FB386A45F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load,
   input  logic [N*M-1:0]   key,
   output logic             key_valid,
   output logic             key_busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_decrypt,
   input  logic [2*N-1:0]   in_block,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_block,
   output logic             out_decrypt
);

   localparam int unsigned KW = (T > 1) ? $clog2(T) : 1;
   localparam int unsigned NR = T / UNROLL;

   typedef enum logic [2:0] {
      ST_NOKEY,
      ST_EXPAND,
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     x_q, x_d;
   logic [N-1:0]     y_q, y_d;
   logic             dec_q, dec_d;
   logic             key_valid_q, key_valid_d;
   logic             out_valid_q, out_valid_d;
   logic [2*N-1:0]   out_block_q, out_block_d;
   logic             out_decrypt_q, out_decrypt_d;
   logic [N-1:0]     rk_q [T];
   logic [N-1:0]     rk_d [T];

   logic [N-1:0]     exp_key;
   logic [N-1:0]     round_x, round_y;

   function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned r);
      return (v << r) | (v >> (N - r));
   endfunction

   function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned r);
      return rol(v, N - r);
   endfunction

   function automatic logic [N-1:0] f_round(input logic [N-1:0] v);
      return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
   endfunction

   assign key_busy    = (state_q == ST_EXPAND);
   assign key_valid   = key_valid_q;
   assign in_ready    = (state_q == ST_IDLE) && !key_load;
   assign out_valid   = out_valid_q;
   assign out_block   = out_block_q;
   assign out_decrypt = out_decrypt_q;

   // Next round key k(cnt) from keys already in the file.
   always_comb begin
      logic [N-1:0] tmp;
      logic [5:0]   zi;
      tmp = ror(rk_q[cnt_q - KW'(1)], 3);
      if (M == 4) begin
         tmp = tmp ^ rk_q[cnt_q - KW'(3)];
      end
      tmp     = tmp ^ ror(tmp, 1);
      zi      = 6'((32'(cnt_q) - M) % 62);
      exp_key = ~rk_q[cnt_q - KW'(M)] ^ tmp ^ N'(Z[zi]) ^ N'(3);
   end

   // UNROLL rounds; decrypt walks the key file downwards.
   always_comb begin
      logic [N-1:0]  t;
      logic [KW-1:0] idx;
      round_x = x_q;
      round_y = y_q;
      for (int unsigned u = 0; u < UNROLL; u++) begin
         idx = KW'(32'(cnt_q) * UNROLL + u);
         if (dec_q) begin
            idx = KW'(T - 1) - idx;
         end
         t       = round_x;
         round_x = round_y ^ f_round(round_x) ^ rk_q[idx];
         round_y = t;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      x_d           = x_q;
      y_d           = y_q;
      dec_d         = dec_q;
      key_valid_d   = key_valid_q;
      out_valid_d   = out_valid_q;
      out_block_d   = out_block_q;
      out_decrypt_d = out_decrypt_q;
      rk_d          = rk_q;

      case (state_q)
         ST_EXPAND: begin
            rk_d[cnt_q] = exp_key;
            if (cnt_q == KW'(T - 1)) begin
               state_d     = ST_IDLE;
               key_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + KW'(1);
            end
         end
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               dec_d   = in_decrypt;
               cnt_d   = '0;
               state_d = ST_RUN;
               if (in_decrypt) begin
                  x_d = in_block[N-1:0];
                  y_d = in_block[2*N-1:N];
               end else begin
                  x_d = in_block[2*N-1:N];
                  y_d = in_block[N-1:0];
               end
            end
         end
         ST_RUN: begin
            x_d = round_x;
            y_d = round_y;
            if (cnt_q == KW'(NR - 1)) begin
               state_d       = ST_DONE;
               out_valid_d   = 1'b1;
               out_decrypt_d = dec_q;
               out_block_d   = dec_q ? {round_y, round_x} : {round_x, round_y};
            end else begin
               cnt_d = cnt_q + KW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      // A key load pre-empts everything except an in-flight or held block.
      if (key_load && (state_q == ST_NOKEY || state_q == ST_IDLE || state_q == ST_EXPAND)) begin
         for (int unsigned m = 0; m < M; m++) begin
            rk_d[m] = key[m*N +: N];
         end
         cnt_d       = KW'(M);
         state_d     = ST_EXPAND;
         key_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_NOKEY;
         cnt_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         dec_q         <= 1'b0;
         key_valid_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_block_q   <= '0;
         out_decrypt_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         x_q           <= x_d;
         y_q           <= y_d;
         dec_q         <= dec_d;
         key_valid_q   <= key_valid_d;
         out_valid_q   <= out_valid_d;
         out_block_q   <= out_block_d;
         out_decrypt_q <= out_decrypt_d;
      end
   end

   // Round-key file is not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rk_q <= rk_d;
      end
   end

endmodule

// File: tb/tb_simon_keyed_core.sv
// Scoreboard bench for simon_keyed_core: a one-round-per-cycle build and an UNROLL=4 build,
// checked against a word-level Simon32/64 reference model.
module tb_simon_keyed_core;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  key_load, in_valid, in_decrypt, out_ready;
   logic [63:0] key [2];
   logic [31:0] in_block [2];
   logic [1:0]  key_valid, key_busy, in_ready, out_valid, out_decrypt;
   logic [31:0] out_block [2];

   always #5 clk = ~clk;

   simon_keyed_core u_dut1 (
      .clk(clk), .rst(rst[0]), .key_load(key_load[0]), .key(key[0]),
      .key_valid(key_valid[0]), .key_busy(key_busy[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_decrypt(in_decrypt[0]),
      .in_block(in_block[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_block(out_block[0]), .out_decrypt(out_decrypt[0])
   );

   simon_keyed_core #(.UNROLL(4)) u_dut4 (
      .clk(clk), .rst(rst[1]), .key_load(key_load[1]), .key(key[1]),
      .key_valid(key_valid[1]), .key_busy(key_busy[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_decrypt(in_decrypt[1]),
      .in_block(in_block[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_block(out_block[1]), .out_decrypt(out_decrypt[1])
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit rnd_bp = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] mk [2][32];

   function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
      logic [31:0] w;
      w = {v, v};
      w = w << r;
      return w[31:16];
   endfunction

   function automatic logic [15:0] f16(input logic [15:0] v);
      return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
   endfunction

   task automatic model_expand(input int d, input logic [63:0] k);
      logic [61:0] z;
      logic [15:0] tmp;
      z = 62'h19C3522FB386A45F;
      for (int i = 0; i < 4; i++) mk[d][i] = k[16*i +: 16];
      for (int i = 4; i < 32; i++) begin
         tmp = rol16(mk[d][i-1], 13) ^ mk[d][i-3];
         mk[d][i] = 16'hFFFC ^ {15'd0, z[i-4]} ^ mk[d][i-4] ^ tmp ^ rol16(tmp, 15);
      end
   endtask

   function automatic logic [31:0] m_enc(input int d, input logic [31:0] b);
      logic [15:0] x, y, t;
      x = b[31:16];
      y = b[15:0];
      for (int i = 0; i < 32; i++) begin
         t = x;
         x = y ^ f16(x) ^ mk[d][i];
         y = t;
      end
      return {x, y};
   endfunction

   function automatic logic [31:0] m_dec(input int d, input logic [31:0] b);
      logic [15:0] x, y, t;
      x = b[31:16];
      y = b[15:0];
      for (int i = 31; i >= 0; i--) begin
         t = y;
         y = x ^ f16(y) ^ mk[d][i];
         x = t;
      end
      return {x, y};
   endfunction

   // ---------------- scoreboard + monitor ----------------
   typedef struct {
      logic [31:0] blk;
      logic        dec;
      int          d;
      int          acc;
   } exp_t;

   exp_t       sbq[$];
   logic [1:0] ov_prev = '0;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (out_valid[d] === 1'b1) begin
            if (sbq.size() == 0 || sbq[0].d != d) begin
               chk($sformatf("unexpected_out_dut%0d", d), {32'd0, out_block[d]}, 64'hDEAD);
            end else begin
               if (!ov_prev[d]) chk($sformatf("latency_dut%0d", d), 64'(cyc - sbq[0].acc),
                                    (d == 0) ? 64'd32 : 64'd8);
               chk($sformatf("in_ready_in_done_dut%0d", d), {63'd0, in_ready[d]}, 64'd0);
               chk($sformatf("out_block_dut%0d", d), {32'd0, out_block[d]}, {32'd0, sbq[0].blk});
               if (out_ready[d]) begin
                  chk($sformatf("out_decrypt_dut%0d", d), {63'd0, out_decrypt[d]}, {63'd0, sbq[0].dec});
                  void'(sbq.pop_front());
               end
            end
         end
         ov_prev[d] = out_valid[d] === 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rnd_bp) begin
         #1;
         out_ready[0] = ($urandom_range(0, 3) != 0);
         out_ready[1] = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_expand(input int d);
      int n;
      chk("busy_after_load", {63'd0, key_busy[d]}, 64'd1);
      chk("valid_low_while_busy", {63'd0, key_valid[d]}, 64'd0);
      n = 0;
      @(negedge clk);
      while (key_busy[d] && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", 64'(n), 64'd28);
      chk("key_valid_after_expand", {63'd0, key_valid[d]}, 64'd1);
   endtask

   task automatic load_key(input int d, input logic [63:0] k);
      tick();
      key[d] = k;
      key_load[d] = 1'b1;
      model_expand(d, k);
      tick();
      key_load[d] = 1'b0;
      wait_expand(d);
   endtask

   task automatic send(input int d, input logic [31:0] b, input logic dec,
                       input logic [31:0] e, input bit push);
      int n;
      tick();
      in_block[d] = b;
      in_decrypt[d] = dec;
      in_valid[d] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready[d] && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready[d]) chk("send_timeout", 64'd0, 64'd1);
      else if (push) sbq.push_back('{blk: e, dec: dec, d: d, acc: cyc + 1});
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         chk("drain_timeout", 64'(sbq.size()), 64'd0);
         sbq.delete();
      end
   endtask

   localparam logic [63:0] KEY0 = 64'h1918111009080100;
   localparam logic [31:0] PT   = 32'h65656877;
   localparam logic [31:0] CT   = 32'hC69BE9BB;

   initial begin
      logic [31:0] strm [3];
      logic [31:0] b;
      logic [63:0] rk;
      logic        dm;
      int          n;
      strm[0] = 32'h41424344;
      strm[1] = 32'h77686565;
      strm[2] = 32'h65656877;

      rst = 2'b11;
      key_load = '0;
      in_valid = '0;
      in_decrypt = '0;
      out_ready = 2'b11;
      key[0] = '0;
      key[1] = '0;
      in_block[0] = '0;
      in_block[1] = '0;
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_key_valid", {63'd0, key_valid[d]}, 64'd0);
         chk("rst_key_busy", {63'd0, key_busy[d]}, 64'd0);
         chk("rst_in_ready", {63'd0, in_ready[d]}, 64'd0);
         chk("rst_out_valid", {63'd0, out_valid[d]}, 64'd0);
         chk("rst_out_decrypt", {63'd0, out_decrypt[d]}, 64'd0);
         chk("rst_out_block", {32'd0, out_block[d]}, 64'd0);
      end
      rst = 2'b00;

      // No key yet: block must never be taken.
      in_block[0] = PT;
      in_valid[0] = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("nokey_in_ready", {63'd0, in_ready[0]}, 64'd0);
      end
      tick();
      in_valid[0] = 1'b0;

      load_key(0, KEY0);
      send(0, PT, 1'b0, CT, 1'b1);
      drain();
      send(0, CT, 1'b1, PT, 1'b1);
      drain();

      // Back-pressure: hold the result for 10 cycles.
      out_ready[0] = 1'b0;
      send(0, PT, 1'b0, CT, 1'b1);
      n = 0;
      while (!out_valid[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid_seen", {63'd0, out_valid[0]}, 64'd1);
      repeat (10) @(negedge clk);
      tick();
      out_ready[0] = 1'b1;
      drain();
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after_transfer", {63'd0, in_ready[0]}, 64'd1);

      // key_load during RUN is ignored.
      send(0, PT, 1'b0, CT, 1'b1);
      repeat (5) tick();
      key[0] = 64'h0123456789ABCDEF;
      key_load[0] = 1'b1;
      tick();
      key_load[0] = 1'b0;
      chk("run_key_load_ignored_busy", {63'd0, key_busy[0]}, 64'd0);
      drain();
      chk("run_key_load_key_valid", {63'd0, key_valid[0]}, 64'd1);

      // Simultaneous key_load and in_valid in IDLE: key wins, block dropped.
      tick();
      key[0] = KEY0;
      key_load[0] = 1'b1;
      in_block[0] = PT;
      in_valid[0] = 1'b1;
      @(negedge clk);
      chk("collide_in_ready", {63'd0, in_ready[0]}, 64'd0);
      @(posedge clk);
      #1;
      key_load[0] = 1'b0;
      in_valid[0] = 1'b0;
      wait_expand(0);

      // Reset mid-RUN aborts and drops the key.
      send(0, PT, 1'b0, CT, 1'b0);
      repeat (10) tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      chk("abort_out_valid", {63'd0, out_valid[0]}, 64'd0);
      chk("abort_key_valid", {63'd0, key_valid[0]}, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready[0]}, 64'd0);
      repeat (40) tick();
      load_key(0, KEY0);
      send(0, PT, 1'b0, CT, 1'b1);
      drain();

      // Random key and blocks under random back-pressure.
      rk = {$urandom, $urandom};
      load_key(0, rk);
      rnd_bp = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b = $urandom;
         dm = 1'($urandom_range(0, 1));
         send(0, b, dm, dm ? m_dec(0, b) : m_enc(0, b), 1'b1);
      end
      drain();
      rnd_bp = 1'b0;
      tick();
      out_ready = 2'b11;

      // UNROLL = 4 build.
      load_key(1, KEY0);
      send(1, PT, 1'b0, CT, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) send(1, strm[i], 1'b0, m_enc(1, strm[i]), 1'b1);
      drain();
      for (int i = 0; i < 3; i++) send(1, m_enc(1, strm[i]), 1'b1, strm[i], 1'b1);
      drain();
      rk = {$urandom, $urandom};
      load_key(1, rk);
      rnd_bp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b = $urandom;
         dm = 1'($urandom_range(0, 1));
         send(1, b, dm, dm ? m_dec(1, b) : m_enc(1, b), 1'b1);
      end
      drain();
      rnd_bp = 1'b0;

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
